// File: rtl/boss_sprite_fetch_pkg.sv
// Shared constants and types for the boss sprite fetch path and its animation FSM.
package boss_pkg;
    localparam int SPRITE_W    = 256;
    localparam int SPRITE_H    = 224;
    localparam int FRAMES      = 8;
    localparam int FRAME_DIV   = 6;
    localparam int HURT_LEN    = 30;
    localparam int ADDR_W      = 19;
    localparam int LOG2_W      = $clog2(SPRITE_W);
    localparam int FRAME_BYTES = SPRITE_W * SPRITE_H;
    localparam int FRAME_W     = $clog2(FRAMES);
    localparam int DIV_W       = $clog2(FRAME_DIV);
    localparam int HURT_W      = $clog2(HURT_LEN);
    localparam logic [3:0] TRANSP = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HURT = 2'd2
    } boss_anim_t;
endpackage

// File: rtl/boss_sprite_fetch_if.sv
// Scan/position inputs, ROM port and mixer outputs of the boss sprite fetch block.
interface boss_sprite_fetch_if;
    import boss_pkg::*;

    logic              frame_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        BossX;
    logic [9:0]        BossY;
    logic              face_left;
    logic              anim_en;
    logic              hurt;
    logic [3:0]        rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        pixel_idx;
    logic              pixel_on;
    logic              hurt_flash;
    logic [2:0]        frame_num;

    modport master (
        output frame_start, DrawX, DrawY, BossX, BossY, face_left, anim_en, hurt, rom_data,
        input  rom_addr, pixel_idx, pixel_on, hurt_flash, frame_num
    );

    modport slave (
        input  frame_start, DrawX, DrawY, BossX, BossY, face_left, anim_en, hurt, rom_data,
        output rom_addr, pixel_idx, pixel_on, hurt_flash, frame_num
    );
endinterface

// File: rtl/boss_sprite_fetch_anim_fsm.sv
// Boss animation FSM: idle, walk cycle stepped every FRAME_DIV vsyncs, hurt flash.
module boss_anim_fsm
    import boss_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               anim_en,
    input  logic               hurt,
    output logic [FRAME_W-1:0] frame_num,
    output logic [ADDR_W-1:0]  frame_base,
    output logic               hurt_flash
);
    boss_anim_t         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [HURT_W-1:0]  hurt_cnt_q, hurt_cnt_d;
    logic [FRAME_W-1:0] frame_num_q, frame_num_d;
    logic [ADDR_W-1:0]  frame_base_q, frame_base_d;
    logic               hurt_flash_q, hurt_flash_d;
    logic               advance_s;
    logic               go_idle_s;

    // State, counters and frame registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            hurt_cnt_q   <= '0;
            frame_num_q  <= '0;
            frame_base_q <= '0;
            hurt_flash_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            hurt_cnt_q   <= hurt_cnt_d;
            frame_num_q  <= frame_num_d;
            frame_base_q <= frame_base_d;
            hurt_flash_q <= hurt_flash_d;
        end
    end

    // Next state; hurt overrides frame_start, so its counter always restarts at 0.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        hurt_cnt_d   = hurt_cnt_q;
        frame_num_d  = frame_num_q;
        frame_base_d = frame_base_q;
        advance_s    = 1'b0;
        go_idle_s    = 1'b0;

        if (hurt) begin
            state_d    = HURT;
            hurt_cnt_d = '0;
        end else if (frame_start) begin
            case (state_q)
                IDLE: begin
                    if (anim_en) begin
                        state_d   = PLAY;
                        advance_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PLAY: begin
                    if (anim_en) begin
                        advance_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end
                HURT: begin
                    if (hurt_cnt_q == HURT_W'(HURT_LEN - 1)) begin
                        if (anim_en) begin
                            state_d = PLAY;
                        end else begin
                            go_idle_s = 1'b1;
                        end
                    end else begin
                        hurt_cnt_d = hurt_cnt_q + HURT_W'(1);
                    end
                end
                default: begin
                    go_idle_s = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (go_idle_s) begin
            state_d      = IDLE;
            div_d        = '0;
            frame_num_d  = '0;
            frame_base_d = '0;
        end else if (advance_s) begin
            if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d = '0;
                if (frame_num_q == FRAME_W'(FRAMES - 1)) begin
                    frame_num_d  = '0;
                    frame_base_d = '0;
                end else begin
                    frame_num_d  = frame_num_q + FRAME_W'(1);
                    frame_base_d = frame_base_q + ADDR_W'(FRAME_BYTES);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = div_d;
        end

        hurt_flash_d = (state_d == HURT) && hurt_cnt_d[2];
    end

    assign frame_num  = frame_num_q;
    assign frame_base = frame_base_q;
    assign hurt_flash = hurt_flash_q;
endmodule

// File: rtl/boss_sprite_fetch.sv
// Boss sprite ROM address generator with a fixed 2-cycle scan-to-pixel pipeline.
module boss_sprite_fetch
    import boss_pkg::*;
(
    input logic                Clk,
    input logic                Reset_n,
    boss_sprite_fetch_if.slave bus
);
    logic [10:0]        rel_x_s, rel_y_s;
    logic               hit0_s;
    logic [ADDR_W-1:0]  col_s, row_off_s, addr_s, frame_base_s;
    logic [FRAME_W-1:0] frame_num_s;
    logic               hurt_flash_s;

    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               hit1_q, hit1_d;
    logic [3:0]         pixel_idx_q, pixel_idx_d;
    logic               pixel_on_q, pixel_on_d;

    boss_anim_fsm u_anim_fsm (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .frame_start (bus.frame_start),
        .anim_en     (bus.anim_en),
        .hurt        (bus.hurt),
        .frame_num   (frame_num_s),
        .frame_base  (frame_base_s),
        .hurt_flash  (hurt_flash_s)
    );

    // Box test and address math; bit 10 of the 11-bit difference is the sign.
    always_comb begin
        rel_x_s   = {1'b0, bus.DrawX} - {1'b0, bus.BossX};
        rel_y_s   = {1'b0, bus.DrawY} - {1'b0, bus.BossY};
        hit0_s    = !rel_x_s[10] && (rel_x_s < 11'(SPRITE_W)) &&
                    !rel_y_s[10] && (rel_y_s < 11'(SPRITE_H));
        if (bus.face_left) begin
            col_s = ADDR_W'(SPRITE_W - 1) - ADDR_W'(rel_x_s);
        end else begin
            col_s = ADDR_W'(rel_x_s);
        end
        row_off_s = ADDR_W'(rel_y_s) << LOG2_W;
        addr_s    = frame_base_s + row_off_s + col_s;

        rom_addr_d  = hit0_s ? addr_s : rom_addr_q;
        hit1_d      = hit0_s;
        pixel_idx_d = bus.rom_data;
        pixel_on_d  = hit1_q && (bus.rom_data != TRANSP);
    end

    // Pipeline stages 1 and 2.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            hit1_q      <= 1'b0;
            pixel_idx_q <= 4'h0;
            pixel_on_q  <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            hit1_q      <= hit1_d;
            pixel_idx_q <= pixel_idx_d;
            pixel_on_q  <= pixel_on_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.pixel_idx  = pixel_idx_q;
    assign bus.pixel_on   = pixel_on_q;
    assign bus.hurt_flash = hurt_flash_s;
    assign bus.frame_num  = frame_num_s;
endmodule

// File: tb/tb_boss_sprite_fetch.sv
// Bench for boss_sprite_fetch: directed box/mirror/animation/hurt cases plus random traffic vs a pulse-count model.
module tb_boss_sprite_fetch;
    import boss_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    boss_sprite_fetch_if bus ();

    boss_sprite_fetch dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic       v_ae = 1'b0, v_fl = 1'b0, v_ft = 1'b0;
    logic [9:0] v_dx = 10'd0, v_dy = 10'd0, v_bx = 10'd0, v_by = 10'd0;

    // ROM content: a simple address hash; v_ft forces a transparent read.
    function automatic logic [3:0] rom_fn(input logic [18:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]} ^ 4'h5;
    endfunction

    assign bus.rom_data = v_ft ? 4'h0 : rom_fn(bus.rom_addr);

    // Reference model: animation described by pulse counts, pipeline by expected values.
    int          m_mode = 0;   // 0 idle, 1 walk, 2 hurt
    int          m_play = 0;   // walk pulses accumulated since last return to idle
    int          m_hurt = 0;   // pulses since the last hurt
    logic [18:0] e_addr = 19'd0;
    logic        e_hit1 = 1'b0;
    logic [3:0]  e_idx  = 4'h0;
    logic        e_on   = 1'b0;

    function automatic int exp_frame();
        return (m_mode == 0) ? 0 : (m_play / FRAME_DIV) % FRAMES;
    endfunction

    function automatic logic exp_flash();
        return (m_mode == 2) && (((m_hurt / 4) % 2) == 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_play = 0; m_hurt = 0;
        e_addr = 19'd0; e_hit1 = 1'b0; e_idx = 4'h0; e_on = 1'b0;
    endtask

    task automatic model_edge(input logic fs, input logic hu);
        int rx, ry, col;
        logic [3:0] rd;
        logic hit0;
        rd    = v_ft ? 4'h0 : rom_fn(e_addr);
        e_idx = rd;
        e_on  = e_hit1 && (rd != TRANSP);
        rx    = int'(v_dx) - int'(v_bx);
        ry    = int'(v_dy) - int'(v_by);
        hit0  = (rx >= 0) && (rx < SPRITE_W) && (ry >= 0) && (ry < SPRITE_H);
        col   = v_fl ? (SPRITE_W - 1 - rx) : rx;
        if (hit0) e_addr = 19'(exp_frame() * FRAME_BYTES + ry * SPRITE_W + col);
        e_hit1 = hit0;
        if (hu) begin
            m_mode = 2; m_hurt = 0;
        end else if (fs) begin
            if (m_mode == 0) begin
                if (v_ae) begin m_mode = 1; m_play = 1; end
            end else if (m_mode == 1) begin
                if (v_ae) m_play++;
                else begin m_mode = 0; m_play = 0; end
            end else begin
                m_hurt++;
                if (m_hurt == HURT_LEN) begin
                    if (v_ae) m_mode = 1;
                    else begin m_mode = 0; m_play = 0; end
                end
            end
        end
    endtask

    // One clock: drive at negedge, model the posedge, compare at the next negedge.
    task automatic cycle(input logic fs, input logic hu);
        bus.frame_start = fs;
        bus.hurt        = hu;
        bus.anim_en     = v_ae;
        bus.face_left   = v_fl;
        bus.DrawX       = v_dx;
        bus.DrawY       = v_dy;
        bus.BossX       = v_bx;
        bus.BossY       = v_by;
        model_edge(fs, hu);
        @(posedge Clk);
        @(negedge Clk);
        check_eq("rom_addr",   32'(bus.rom_addr),   32'(e_addr));
        check_eq("pixel_on",   32'(bus.pixel_on),   32'(e_on));
        check_eq("pixel_idx",  32'(bus.pixel_idx),  32'(e_idx));
        check_eq("frame_num",  32'(bus.frame_num),  32'(exp_frame()));
        check_eq("hurt_flash", 32'(bus.hurt_flash), 32'(exp_flash()));
    endtask

    task automatic pulse(input logic hu);
        cycle(1'b1, hu);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rom_addr"},   32'(bus.rom_addr),   32'd0);
        check_eq({tag, "_pixel_on"},   32'(bus.pixel_on),   32'd0);
        check_eq({tag, "_pixel_idx"},  32'(bus.pixel_idx),  32'd0);
        check_eq({tag, "_hurt_flash"}, 32'(bus.hurt_flash), 32'd0);
        check_eq({tag, "_frame_num"},  32'(bus.frame_num),  32'd0);
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.hurt = 1'b0; bus.anim_en = 1'b0; bus.face_left = 1'b0;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.BossX = 10'd0; bus.BossY = 10'd0;
        model_reset();
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset_n = 1'b1;

        // Box edges at BossX=100, BossY=50, frame 0
        v_bx = 10'd100; v_by = 10'd50; v_dx = 10'd100; v_dy = 10'd50;
        cycle(1'b0, 1'b0);
        check_eq("edge_tl_addr", 32'(bus.rom_addr), 32'd0);
        v_dx = 10'd355; v_dy = 10'd273;
        cycle(1'b0, 1'b0);
        check_eq("edge_br_addr", 32'(bus.rom_addr), 32'd57343);
        check_eq("edge_tl_on", 32'(bus.pixel_on), 32'd1);
        v_dx = 10'd356;
        cycle(1'b0, 1'b0);
        check_eq("edge_hold_addr", 32'(bus.rom_addr), 32'd57343);
        v_dx = 10'd99;
        cycle(1'b0, 1'b0);
        check_eq("edge_right_off", 32'(bus.pixel_on), 32'd0);
        cycle(1'b0, 1'b0);
        check_eq("edge_left_off", 32'(bus.pixel_on), 32'd0);

        // Mirror and transparency
        v_fl = 1'b1; v_dx = 10'd100; v_dy = 10'd50;
        cycle(1'b0, 1'b0);
        check_eq("mirror_addr", 32'(bus.rom_addr), 32'd255);
        v_ft = 1'b1;
        cycle(1'b0, 1'b0);
        check_eq("transp_off", 32'(bus.pixel_on), 32'd0);
        v_ft = 1'b0; v_fl = 1'b0;

        // Negative offset must not alias into the box
        v_bx = 10'd900; v_dx = 10'd5;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check_eq("neg_off", 32'(bus.pixel_on), 32'd0);

        // Animation stepping and wrap
        v_bx = 10'd100; v_dx = 10'd100; v_dy = 10'd50; v_ae = 1'b1;
        for (int i = 0; i < 6; i++) pulse(1'b0);
        check_eq("anim_frame1", 32'(bus.frame_num), 32'd1);
        check_eq("anim_base1", 32'(bus.rom_addr), 32'd57344);
        for (int i = 6; i < 48; i++) pulse(1'b0);
        check_eq("anim_wrap_frame", 32'(bus.frame_num), 32'd0);
        check_eq("anim_wrap_base", 32'(bus.rom_addr), 32'd0);
        for (int i = 0; i < 8; i++) pulse(1'b0);
        v_ae = 1'b0;
        pulse(1'b0);
        check_eq("anim_idle_frame", 32'(bus.frame_num), 32'd0);

        // Hurt flash at frame 3, restarted at pulse 20
        v_ae = 1'b1;
        for (int i = 0; i < 18; i++) pulse(1'b0);
        check_eq("hurt_pre_frame", 32'(bus.frame_num), 32'd3);
        pulse(1'b1);
        for (int k = 1; k <= 50; k++) begin
            pulse(k == 20);
            if (k == 3)  check_eq("hurt_flash_k3", 32'(bus.hurt_flash), 32'd0);
            if (k == 4)  check_eq("hurt_flash_k4", 32'(bus.hurt_flash), 32'd1);
            if (k == 25) check_eq("hurt_frozen", 32'(bus.frame_num), 32'd3);
            if (k == 32) check_eq("hurt_extended", 32'(bus.hurt_flash), 32'd1);
            if (k == 49) check_eq("hurt_flash_k49", 32'(bus.hurt_flash), 32'd1);
            if (k == 50) check_eq("hurt_exit_flash", 32'(bus.hurt_flash), 32'd0);
        end
        for (int i = 0; i < 6; i++) pulse(1'b0);
        check_eq("hurt_resume_frame", 32'(bus.frame_num), 32'd4);

        // Random traffic around the box
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) v_ae = ~v_ae;
            if ($urandom_range(0, 31) == 0) v_fl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 255) == 0) begin
                v_bx = 10'($urandom_range(0, 1023));
                v_by = 10'($urandom_range(0, 1023));
            end
            v_dx = 10'(int'(v_bx) + int'($urandom_range(0, 300)) - 20);
            v_dy = 10'(int'(v_by) + int'($urandom_range(0, 260)) - 20);
            v_ft = ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0);
        end

        // Asynchronous reset in the middle of a line
        v_ft = 1'b0; v_fl = 1'b0; v_bx = 10'd100; v_by = 10'd50; v_dx = 10'd100; v_dy = 10'd50;
        cycle(1'b0, 1'b0);
        #2 Reset_n = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        cycle(1'b0, 1'b0);
        check_eq("post_reset_on_early", 32'(bus.pixel_on), 32'd0);
        cycle(1'b0, 1'b0);
        check_eq("post_reset_on", 32'(bus.pixel_on), 32'd1);
        check_eq("post_reset_frame", 32'(bus.frame_num), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
